// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared definitions for the generic inter-stage pipeline register.
//            Holds occupancy codes, default widths/mask, the packed payload
//            field layout of the ID/EX, EX/MEM and MEM/WB stages, and a helper
//            that turns the two storage valid bits into an occupancy count.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Occupancy encodings reported on the occupancy port.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Default geometry of a stage register.
    localparam int PIPE_DATA_W = 128;
    localparam int PIPE_CNT_W  = 16;

    // Common field widths.
    localparam int PC_W   = 32;
    localparam int WORD_W = 32;
    localparam int WR_W   = 5;

    // ID/EX payload layout (LSB offsets). Bit 0 is the have_inst trace bit.
    localparam int IDEX_HAVE_LSB    = 0;
    localparam int IDEX_PC_LSB      = 1;
    localparam int IDEX_NPC_OP_LSB  = 33;   // 2 bits
    localparam int IDEX_RF_WESL_LSB = 35;   // 2 bits
    localparam int IDEX_ALU_OP_LSB  = 37;   // 4 bits
    localparam int IDEX_DRAM_WE_LSB = 41;
    localparam int IDEX_WE_LSB      = 42;
    localparam int IDEX_WR_LSB      = 43;   // 5 bits
    localparam int IDEX_ALUA_LSB    = 48;   // operand A select
    localparam int IDEX_ALUB_LSB    = 49;   // operand B select
    localparam int IDEX_EXT_LSB     = 50;   // 32 bits
    localparam int IDEX_RD2_LSB     = 82;   // 32 bits, ends at bit 113

    // EX/MEM payload layout.
    localparam int EXMEM_HAVE_LSB    = 0;
    localparam int EXMEM_PC_LSB      = 1;
    localparam int EXMEM_RF_WESL_LSB = 33;  // 2 bits
    localparam int EXMEM_DRAM_WE_LSB = 35;
    localparam int EXMEM_WE_LSB      = 36;
    localparam int EXMEM_WR_LSB      = 37;  // 5 bits
    localparam int EXMEM_ALUC_LSB    = 42;  // 32 bits, ALU result
    localparam int EXMEM_RD2_LSB     = 74;  // 32 bits, store data

    // MEM/WB payload layout.
    localparam int MEMWB_HAVE_LSB    = 0;
    localparam int MEMWB_PC_LSB      = 1;
    localparam int MEMWB_RF_WESL_LSB = 33;  // 2 bits
    localparam int MEMWB_WE_LSB      = 35;
    localparam int MEMWB_WR_LSB      = 36;  // 5 bits
    localparam int MEMWB_ALUC_LSB    = 41;  // 32 bits
    localparam int MEMWB_DRAM_LSB    = 73;  // 32 bits, load data

    // Number of held beats given the main and skid valid bits.
    function automatic logic [1:0] occ_count(input logic m_v, input logic s_v);
        logic [1:0] occ;
        case ({m_v, s_v})
            2'b00:   occ = OCC_EMPTY;
            2'b11:   occ = OCC_FULL;
            default: occ = OCC_ONE;
        endcase
        return occ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : pipe_sat_cnt
// Purpose  : Saturating up-counter with synchronous clear and count enable.
//            Clear has priority over increment; the count sticks at all-ones.
// Ports    : clk    - rising-edge clock
//            rst_n  - synchronous active-low reset
//            clr_i  - synchronous clear
//            en_i   - count enable
//            cnt_o  - current count
// Revision : 1.0  initial release
// ============================================================================
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Generic valid/ready inter-stage pipeline register carrying one
//            packed payload. Optional two-entry skid buffer (registered
//            up_ready), per-bit bubble mask on flush, and a saturating
//            back-pressure cycle counter.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            flush               - drop held beats, insert bubble
//            up_valid/up_ready/up_data - upstream handshake and payload
//            dn_valid/dn_ready/dn_data - downstream handshake and payload
//            occupancy           - held beats, 0..2
//            clr_cnt/stall_cnt   - stall counter clear / value
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = PIPE_DATA_W,
    parameter int                SKID        = 1,
    parameter logic [DATA_W-1:0] BUBBLE_MASK = {DATA_W{1'b1}},
    parameter int                CNT_W       = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Main register drives the outputs; skid register catches the beat that
    // arrives in the cycle downstream first stalls.
    logic              m_v_q, m_v_d;
    logic [DATA_W-1:0] m_d_q, m_d_d;
    logic              s_v_q, s_v_d;
    logic [DATA_W-1:0] s_d_q, s_d_d;

    logic up_xfer;
    logic dn_xfer;
    logic stall_en;

    assign up_xfer  = up_valid & up_ready;
    assign dn_xfer  = m_v_q & dn_ready;
    assign stall_en = m_v_q & ~dn_ready;

    assign dn_valid  = m_v_q;
    assign dn_data   = m_d_q;
    assign occupancy = occ_count(m_v_q, s_v_q);

    generate
        if (SKID != 0) begin : g_skid
            // Skid empty means there is room for one more beat even if the
            // main register stalls this cycle, so ready needs no dn_ready path.
            assign up_ready = ~s_v_q;

            always_comb begin
                m_v_d = m_v_q;
                m_d_d = m_d_q;
                s_v_d = s_v_q;
                s_d_d = s_d_q;
                if (flush) begin
                    m_v_d = 1'b0;
                    s_v_d = 1'b0;
                    m_d_d = m_d_q & ~BUBBLE_MASK;
                    s_d_d = s_d_q & ~BUBBLE_MASK;
                end else if (!m_v_q || dn_xfer) begin
                    if (s_v_q) begin
                        // Older beat in skid moves forward first.
                        m_v_d = 1'b1;
                        m_d_d = s_d_q;
                        s_v_d = up_xfer;
                        if (up_xfer) begin
                            s_d_d = up_data;
                        end
                    end else begin
                        m_v_d = up_xfer;
                        if (up_xfer) begin
                            m_d_d = up_data;
                        end
                    end
                end else if (up_xfer) begin
                    s_v_d = 1'b1;
                    s_d_d = up_data;
                end
            end
        end else begin : g_noskid
            assign up_ready = ~m_v_q | dn_ready;

            always_comb begin
                m_v_d = m_v_q;
                m_d_d = m_d_q;
                s_v_d = 1'b0;
                s_d_d = '0;
                if (flush) begin
                    m_v_d = 1'b0;
                    m_d_d = m_d_q & ~BUBBLE_MASK;
                end else if (up_xfer) begin
                    m_v_d = 1'b1;
                    m_d_d = up_data;
                end else if (dn_xfer) begin
                    m_v_d = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_v_q <= 1'b0;
            m_d_q <= '0;
            s_v_q <= 1'b0;
            s_d_q <= '0;
        end else begin
            m_v_q <= m_v_d;
            m_d_q <= m_d_d;
            s_v_q <= s_v_d;
            s_d_q <= s_d_d;
        end
    end

    // Flush deliberately does not clear the counter.
    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_cnt),
        .en_i  (stall_en),
        .cnt_o (stall_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg. One instance with the
//            skid buffer (CNT_W=3, mask 0x0F), one without. Expected values
//            come from a FIFO-queue model of each stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int              DW   = 8;
    localparam int              SCW  = 3;
    localparam int              NCW  = 16;
    localparam logic [DW-1:0]   MASK = 8'h0F;
    localparam int              SMAX = (1 << SCW) - 1;
    localparam int              NMAX = (1 << NCW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            s_flush, s_up_valid, s_up_ready, s_dn_valid, s_dn_ready, s_clr;
    logic [DW-1:0]   s_up_data, s_dn_data;
    logic [1:0]      s_occ;
    logic [SCW-1:0]  s_stall;

    logic            n_flush, n_up_valid, n_up_ready, n_dn_valid, n_dn_ready, n_clr;
    logic [DW-1:0]   n_up_data, n_dn_data;
    logic [1:0]      n_occ;
    logic [NCW-1:0]  n_stall;

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .BUBBLE_MASK(MASK), .CNT_W(SCW)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .up_valid(s_up_valid), .up_ready(s_up_ready), .up_data(s_up_data),
        .dn_valid(s_dn_valid), .dn_ready(s_dn_ready), .dn_data(s_dn_data),
        .occupancy(s_occ), .clr_cnt(s_clr), .stall_cnt(s_stall)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(0), .BUBBLE_MASK(MASK), .CNT_W(NCW)) u_noskid (
        .clk(clk), .rst_n(rst_n), .flush(n_flush),
        .up_valid(n_up_valid), .up_ready(n_up_ready), .up_data(n_up_data),
        .dn_valid(n_dn_valid), .dn_ready(n_dn_ready), .dn_data(n_dn_data),
        .occupancy(n_occ), .clr_cnt(n_clr), .stall_cnt(n_stall)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each stage is a FIFO of capacity 2 (skid) or 1.
    logic [DW-1:0] sq[$];
    logic [DW-1:0] nq[$];
    int scnt = 0;
    int ncnt = 0;

    // Packed views {valid, occupancy, up_ready, stall, data-if-valid}.
    function automatic logic [14:0] s_exp();
        logic [DW-1:0] d;
        d = '0;
        if (sq.size() > 0) d = sq[0];
        return {(sq.size() > 0), 2'(sq.size()), (sq.size() < 2), 3'(scnt), d};
    endfunction

    function automatic logic [14:0] s_got();
        return {s_dn_valid, s_occ, s_up_ready, s_stall, (s_dn_valid ? s_dn_data : 8'h00)};
    endfunction

    function automatic logic [27:0] n_exp();
        logic [DW-1:0] d;
        d = '0;
        if (nq.size() > 0) d = nq[0];
        return {(nq.size() > 0), 2'(nq.size()), ((nq.size() == 0) || (n_dn_ready === 1'b1)),
                16'(ncnt), d};
    endfunction

    function automatic logic [27:0] n_got();
        return {n_dn_valid, n_occ, n_up_ready, n_stall, (n_dn_valid ? n_dn_data : 8'h00)};
    endfunction

    task automatic s_drive(input logic fl, input logic uv, input logic [DW-1:0] d,
                           input logic dr, input logic cl);
        s_flush = fl; s_up_valid = uv; s_up_data = d; s_dn_ready = dr; s_clr = cl;
    endtask

    task automatic n_drive(input logic fl, input logic uv, input logic [DW-1:0] d,
                           input logic dr, input logic cl);
        n_flush = fl; n_up_valid = uv; n_up_data = d; n_dn_ready = dr; n_clr = cl;
    endtask

    // Advance one clock and apply the handshake rules to both models.
    task automatic tick();
        logic rs, s_fl, n_fl, s_cl, n_cl, s_ux, s_dx, s_st, n_ux, n_dx, n_st;
        logic [DW-1:0] s_ud, n_ud;
        rs   = rst_n;
        s_fl = s_flush;  n_fl = n_flush;
        s_cl = s_clr;    n_cl = n_clr;
        s_ud = s_up_data; n_ud = n_up_data;
        s_ux = s_up_valid && (sq.size() < 2);
        s_dx = (sq.size() > 0) && s_dn_ready;
        s_st = (sq.size() > 0) && !s_dn_ready;
        n_ux = n_up_valid && ((nq.size() == 0) || n_dn_ready);
        n_dx = (nq.size() > 0) && n_dn_ready;
        n_st = (nq.size() > 0) && !n_dn_ready;
        @(posedge clk);
        #1;
        if (!rs) begin
            sq.delete(); nq.delete(); scnt = 0; ncnt = 0;
        end else begin
            if (s_fl) sq.delete();
            else begin
                if (s_dx) void'(sq.pop_front());
                if (s_ux) sq.push_back(s_ud);
            end
            if (n_fl) nq.delete();
            else begin
                if (n_dx) void'(nq.pop_front());
                if (n_ux) nq.push_back(n_ud);
            end
            if (s_cl) scnt = 0; else if (s_st && scnt < SMAX) scnt++;
            if (n_cl) ncnt = 0; else if (n_st && ncnt < NMAX) ncnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_drive(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        n_drive(1'b0, 1'b1, 8'h66, 1'b0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        s_drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        n_checks++;
        if ({s_dn_valid, s_occ, s_up_ready, s_stall, s_dn_data} !== {1'b0, 2'd0, 1'b1, 3'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_skid: got v=%b occ=%0d rdy=%b cnt=%0d data=%h, want 0 0 1 0 00",
                     s_dn_valid, s_occ, s_up_ready, s_stall, s_dn_data);
        end
        n_checks++;
        if ({n_dn_valid, n_occ, n_up_ready, n_stall, n_dn_data} !== {1'b0, 2'd0, 1'b1, 16'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_noskid: got v=%b occ=%0d rdy=%b cnt=%0d data=%h, want 0 0 1 0 00",
                     n_dn_valid, n_occ, n_up_ready, n_stall, n_dn_data);
        end
        tick();
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8) s_drive(1'b0, 1'b1, 8'(i), 1'b1, 1'b0);
            else        s_drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            #1;
            n_checks++;
            if (s_got() !== s_exp()) begin
                n_fail++;
                $display("FAIL stream[%0d]: got %h want %h", i, s_got(), s_exp());
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] dat [10] = '{8'h0A, 8'h0B, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h00, 8'h00, 8'h00};
        logic [9:0]    uv = 10'b0001111111;  // bit i -> step i
        logic [9:0]    dr = 10'b1111100000;
        for (int i = 0; i < 10; i++) begin
            s_drive(1'b0, uv[i], dat[i], dr[i], 1'b0);
            #1;
            n_checks++;
            if (s_got() !== s_exp()) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: got %h want %h", i, s_got(), s_exp());
            end
            if (i == 2) begin
                n_checks++;
                if ({s_occ, s_up_ready} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL bp_full: got occ=%0d rdy=%b want occ=2 rdy=0", s_occ, s_up_ready);
                end
            end
            if (i == 7) begin
                n_checks++;
                if (s_stall !== 3'd4) begin
                    n_fail++;
                    $display("FAIL bp_stall_cnt: got %0d want 4", s_stall);
                end
            end
            tick();
        end
        s_drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_flush();
        s_drive(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0); #1; tick();
        s_drive(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0); #1; tick();
        s_drive(1'b1, 1'b1, 8'h0D, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (s_got() !== s_exp()) begin
            n_fail++;
            $display("FAIL flush_pre: got %h want %h", s_got(), s_exp());
        end
        tick();
        s_drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        n_checks++;
        if ({s_dn_valid, s_occ, s_up_ready, s_dn_data} !== {1'b0, 2'd0, 1'b1, 8'hA0}) begin
            n_fail++;
            $display("FAIL flush_post: got v=%b occ=%0d rdy=%b data=%h want 0 0 1 a0",
                     s_dn_valid, s_occ, s_up_ready, s_dn_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            n_checks++;
            if (s_got() !== s_exp()) begin
                n_fail++;
                $display("FAIL flush_drain[%0d]: got %h want %h", i, s_got(), s_exp());
            end
        end
        s_drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_stall_sat();
        s_drive(1'b0, 1'b1, 8'h42, 1'b0, 1'b0); #1; tick();
        for (int i = 0; i < 10; i++) begin
            s_drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            #1;
            n_checks++;
            if (s_got() !== s_exp()) begin
                n_fail++;
                $display("FAIL stall_sat[%0d]: got %h want %h", i, s_got(), s_exp());
            end
            tick();
        end
        s_drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (s_stall !== 3'd7) begin
            n_fail++;
            $display("FAIL stall_saturated: got %0d want 7", s_stall);
        end
        tick();
        s_drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (s_stall !== 3'd0) begin
            n_fail++;
            $display("FAIL stall_clear: got %0d want 0", s_stall);
        end
        tick();
        s_drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_noskid();
        logic [2:0] pat = 3'b101;
        for (int i = 0; i < 110; i++) begin
            if (i < 30) n_drive(1'b0, 1'b1, 8'($urandom), pat[i % 3], 1'b0);
            else        n_drive(($urandom_range(15, 0) == 0), ($urandom_range(3, 0) != 0),
                                8'($urandom), ($urandom_range(2, 0) != 0), ($urandom_range(31, 0) == 0));
            #1;
            n_checks++;
            if (n_got() !== n_exp()) begin
                n_fail++;
                $display("FAIL noskid[%0d]: got %h want %h", i, n_got(), n_exp());
            end
            tick();
        end
        n_drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(); tick();
    endtask

    task automatic test_random_skid();
        for (int i = 0; i < 200; i++) begin
            s_drive(($urandom_range(15, 0) == 0), ($urandom_range(3, 0) != 0),
                    8'($urandom), ($urandom_range(2, 0) != 0), ($urandom_range(31, 0) == 0));
            #1;
            n_checks++;
            if (s_got() !== s_exp()) begin
                n_fail++;
                $display("FAIL random_skid[%0d]: got %h want %h", i, s_got(), s_exp());
            end
            tick();
        end
        s_drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(); tick(); tick();
    endtask

    task automatic test_reset_midstream();
        s_drive(1'b0, 1'b1, 8'h11, 1'b0, 1'b0); #1; tick();
        s_drive(1'b0, 1'b1, 8'h22, 1'b0, 1'b0); #1; tick();
        n_checks++;
        if (s_occ !== 2'd2) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got occ=%0d want 2", s_occ);
        end
        rst_n = 1'b0;
        s_drive(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        s_drive(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        #1;
        n_checks++;
        if ({s_dn_valid, s_occ, s_up_ready, s_stall, s_dn_data} !== {1'b0, 2'd0, 1'b1, 3'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL rst_mid_post: got v=%b occ=%0d rdy=%b cnt=%0d data=%h, want 0 0 1 0 00",
                     s_dn_valid, s_occ, s_up_ready, s_stall, s_dn_data);
        end
        tick();
        s_drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        n_checks++;
        if ({s_dn_valid, s_dn_data} !== {1'b1, 8'h55}) begin
            n_fail++;
            $display("FAIL rst_mid_resume: got v=%b data=%h want 1 55", s_dn_valid, s_dn_data);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s_drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall_sat();
        test_noskid();
        test_random_skid();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
